// File: rtl/snake_sprite_compositor.sv
// NUM_SNAKES head sprites over background; optional overlap detect via SNAKE_COLLISION_EN.
// Latency ROM_LAT+1 cycles DrawX->rgb; streaming, no backpressure, one pixel per clock.
module snake_sprite_compositor #(
  parameter int          NUM_SNAKES = 2,
  parameter int          SPRITE_DIM = 24,
  parameter int          ROM_LAT    = 1,
  parameter logic [11:0] TRANSP_KEY = 12'hF0F,
  parameter logic [1:0]  RESET_DIR  = 2'b11,
  localparam int         ADDR_W     = $clog2(SPRITE_DIM*SPRITE_DIM)
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic [9:0]                   DrawX,
  input  logic [9:0]                   DrawY,
  input  logic                         blank,
  input  logic                         frame_start,
  input  logic [10*NUM_SNAKES-1:0]     snake_x,
  input  logic [10*NUM_SNAKES-1:0]     snake_y,
  input  logic [2*NUM_SNAKES-1:0]      dir_req,
  input  logic [NUM_SNAKES-1:0]        dir_valid,
  output logic [ADDR_W*NUM_SNAKES-1:0] sprite_addr,
  output logic [2*NUM_SNAKES-1:0]      sprite_dir,
  input  logic [12*NUM_SNAKES-1:0]     sprite_rgb,
  input  logic [11:0]                  bgd_rgb,
  output logic [3:0]                   red,
  output logic [3:0]                   green,
  output logic [3:0]                   blue,
  output logic                         collision,
  output logic [NUM_SNAKES-1:0]        collision_mask
);

  localparam logic [10:0] HALF = 11'(SPRITE_DIM/2);

  logic [10:0]           px, py, px_h, py_h;
  logic [NUM_SNAKES-1:0] hit;
  logic [NUM_SNAKES-1:0] hit_al;
  logic [NUM_SNAKES-1:0] opq;
  logic                  blank_al;

  // Widened to 11 bits so the window edges never wrap at the screen borders.
  assign px   = {1'b0, DrawX};
  assign py   = {1'b0, DrawY};
  assign px_h = px + HALF;
  assign py_h = py + HALF;

  genvar g;
  for (g = 0; g < NUM_SNAKES; g++) begin : g_snake
    logic [10:0] sx, sy, col, row;
    logic [1:0]  pend_q, pend_d, comm_q, comm_d;
    logic        legal;

    assign sx     = {1'b0, snake_x[10*g +: 10]};
    assign sy     = {1'b0, snake_y[10*g +: 10]};
    assign hit[g] = (px_h >= sx) && (px < sx + HALF) && (py_h >= sy) && (py < sy + HALF);
    assign col    = px_h - sx;
    assign row    = py_h - sy;
    assign sprite_addr[ADDR_W*g +: ADDR_W] =
      ADDR_W'(col) + ADDR_W'(row) * ADDR_W'(SPRITE_DIM);

    // Reversal is judged against the committed heading, not the pending one.
    assign legal = dir_valid[g] && (dir_req[2*g +: 2] != (comm_q ^ 2'b10));

    always_comb begin
      pend_d = legal ? dir_req[2*g +: 2] : pend_q;
      comm_d = frame_start ? pend_d : comm_q;
    end

    always_ff @(posedge Clk) begin
      if (Reset) begin
        pend_q <= RESET_DIR;
        comm_q <= RESET_DIR;
      end else begin
        pend_q <= pend_d;
        comm_q <= comm_d;
      end
    end

    assign sprite_dir[2*g +: 2] = comm_q;
    assign opq[g] = hit_al[g] && (sprite_rgb[12*g +: 12] != TRANSP_KEY);
  end

  logic [NUM_SNAKES-1:0] hit_sr_q [ROM_LAT];
  logic [ROM_LAT-1:0]    blank_sr_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < ROM_LAT; i++) begin
        hit_sr_q[i]   <= '0;
        blank_sr_q[i] <= 1'b0;
      end
    end else begin
      hit_sr_q[0]   <= hit;
      blank_sr_q[0] <= blank;
      for (int i = 1; i < ROM_LAT; i++) begin
        hit_sr_q[i]   <= hit_sr_q[i-1];
        blank_sr_q[i] <= blank_sr_q[i-1];
      end
    end
  end

  assign hit_al   = hit_sr_q[ROM_LAT-1];
  assign blank_al = blank_sr_q[ROM_LAT-1];

  logic [11:0] rgb_d, rgb_q;

  // Descending scan so the lowest-index opaque snake is the final winner.
  always_comb begin
    rgb_d = '0;
    if (blank_al) begin
      rgb_d = bgd_rgb;
      for (int i = NUM_SNAKES-1; i >= 0; i--) begin
        if (opq[i]) rgb_d = sprite_rgb[12*i +: 12];
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) rgb_q <= '0;
    else       rgb_q <= rgb_d;
  end

  assign red   = rgb_q[11:8];
  assign green = rgb_q[7:4];
  assign blue  = rgb_q[3:0];

`ifdef SNAKE_COLLISION_EN
  logic [NUM_SNAKES-1:0] acc_q, acc_d, mask_q, mask_d, acc_base;
  logic                  coll_q, coll_d, multi;

  // An overlap on the frame_start pixel lands in the freshly cleared accumulator.
  always_comb begin
    multi    = blank_al && ($countones(opq) > 1);
    acc_base = frame_start ? '0 : acc_q;
    acc_d    = multi ? (acc_base | opq) : acc_base;
    coll_d   = frame_start ? (|acc_q) : coll_q;
    mask_d   = frame_start ? acc_q : mask_q;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      acc_q  <= '0;
      mask_q <= '0;
      coll_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      mask_q <= mask_d;
      coll_q <= coll_d;
    end
  end

  assign collision      = coll_q;
  assign collision_mask = mask_q;
`else
  assign collision      = 1'b0;
  assign collision_mask = '0;
`endif

endmodule

// File: tb/tb_snake_sprite_compositor.sv
// Randomised + directed bench for snake_sprite_compositor against a pixel-level reference model.
module tb_snake_sprite_compositor;

  localparam int          N    = 2;
  localparam int          D    = 24;
  localparam int          L    = 1;
  localparam logic [11:0] KEY  = 12'hF0F;
  localparam logic [1:0]  RD   = 2'b11;
  localparam int          AW   = $clog2(D*D);
  localparam int          HALF = D/2;
`ifdef SNAKE_COLLISION_EN
  localparam bit CE = 1'b1;
`else
  localparam bit CE = 1'b0;
`endif

  logic          Clk = 1'b0;
  logic          Reset;
  logic [9:0]    DrawX, DrawY;
  logic          blank, frame_start;
  logic [10*N-1:0] snake_x, snake_y;
  logic [2*N-1:0]  dir_req;
  logic [N-1:0]    dir_valid;
  logic [AW*N-1:0] sprite_addr;
  logic [2*N-1:0]  sprite_dir;
  logic [12*N-1:0] sprite_rgb;
  logic [11:0]     bgd_rgb;
  logic [3:0]      red, green, blue;
  logic            collision;
  logic [N-1:0]    collision_mask;

  int checks = 0;
  int errors = 0;

  snake_sprite_compositor #(
    .NUM_SNAKES(N), .SPRITE_DIM(D), .ROM_LAT(L), .TRANSP_KEY(KEY), .RESET_DIR(RD)
  ) dut (
    .Clk(Clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
    .frame_start(frame_start), .snake_x(snake_x), .snake_y(snake_y),
    .dir_req(dir_req), .dir_valid(dir_valid), .sprite_addr(sprite_addr),
    .sprite_dir(sprite_dir), .sprite_rgb(sprite_rgb), .bgd_rgb(bgd_rgb),
    .red(red), .green(green), .blue(blue), .collision(collision),
    .collision_mask(collision_mask)
  );

  always #5 Clk = ~Clk;

  typedef struct packed { logic b; logic [N-1:0] h; } rec_t;

  function automatic bit m_hit(int px, int py, int sx, int sy);
    return (px + HALF >= sx) && (px < sx + HALF) && (py + HALF >= sy) && (py < sy + HALF);
  endfunction

  function automatic int m_addr(int px, int py, int sx, int sy);
    return ((px - sx + HALF) + (py - sy + HALF) * D) % (1 << AW);
  endfunction

  function automatic logic [11:0] m_pix(logic b, logic [N-1:0] h, logic [12*N-1:0] spr, logic [11:0] bg);
    if (!b) return 12'h000;
    for (int i = 0; i < N; i++)
      if (h[i] && spr[12*i +: 12] != KEY) return spr[12*i +: 12];
    return bg;
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1; DrawX = '0; DrawY = '0; blank = 1'b0; frame_start = 1'b0;
    snake_x = '0; snake_y = '0; dir_req = '0; dir_valid = '0;
    sprite_rgb = '0; bgd_rgb = '0;
    tick(); tick();
    checks++; if ({red, green, blue} !== 12'h000) begin errors++; $display("FAIL reset_rgb got %h want 000", {red, green, blue}); end
    checks++; if (sprite_dir !== {RD, RD}) begin errors++; $display("FAIL reset_dir got %b want %b", sprite_dir, {RD, RD}); end
    checks++; if (collision !== 1'b0 || collision_mask !== '0) begin errors++; $display("FAIL reset_coll got %b/%b want 0/00", collision, collision_mask); end
    Reset = 1'b0;
  endtask

  task automatic test_addr();
    snake_x = {10'd600, 10'd100}; snake_y = {10'd400, 10'd100};
    DrawX = 10'd88; DrawY = 10'd88; #1;
    checks++; if (sprite_addr[AW-1:0] !== AW'(0)) begin errors++; $display("FAIL addr_corner got %0d want 0", sprite_addr[AW-1:0]); end
    DrawX = 10'd111; DrawY = 10'd111; #1;
    checks++; if (sprite_addr[AW-1:0] !== AW'(575)) begin errors++; $display("FAIL addr_last got %0d want 575", sprite_addr[AW-1:0]); end
    blank = 1'b1; sprite_rgb = {12'h000, 12'h123}; bgd_rgb = 12'h456;
    tick(); tick();
    checks++; if ({red, green, blue} !== 12'h123) begin errors++; $display("FAIL pix_inside got %h want 123", {red, green, blue}); end
    DrawX = 10'd112;
    tick(); tick();
    checks++; if ({red, green, blue} !== 12'h456) begin errors++; $display("FAIL pix_right_edge got %h want 456", {red, green, blue}); end
    snake_x[9:0] = 10'd5; snake_y[9:0] = 10'd5; DrawX = 10'd0; DrawY = 10'd0; #1;
    checks++; if (sprite_addr[AW-1:0] !== AW'(175)) begin errors++; $display("FAIL addr_nowrap got %0d want 175", sprite_addr[AW-1:0]); end
    tick(); tick();
    checks++; if ({red, green, blue} !== 12'h123) begin errors++; $display("FAIL pix_origin got %h want 123", {red, green, blue}); end
    DrawX = 10'd1023;
    tick(); tick();
    checks++; if ({red, green, blue} !== 12'h456) begin errors++; $display("FAIL pix_x1023 got %h want 456", {red, green, blue}); end
  endtask

  task automatic test_composite();
    snake_x = {10'd200, 10'd200}; snake_y = {10'd200, 10'd200};
    DrawX = 10'd200; DrawY = 10'd200; blank = 1'b1; bgd_rgb = 12'h777;
    sprite_rgb = {12'h0A0, 12'hF0F};
    tick(); tick();
    checks++; if ({red, green, blue} !== 12'h0A0) begin errors++; $display("FAIL comp_transp got %h want 0a0", {red, green, blue}); end
    sprite_rgb = {12'h0A0, 12'h123};
    tick(); tick();
    checks++; if ({red, green, blue} !== 12'h123) begin errors++; $display("FAIL comp_prio got %h want 123", {red, green, blue}); end
    sprite_rgb = {KEY, KEY};
    tick(); tick();
    checks++; if ({red, green, blue} !== 12'h777) begin errors++; $display("FAIL comp_bothkey got %h want 777", {red, green, blue}); end
    blank = 1'b0; sprite_rgb = {12'h0A0, 12'h123};
    tick(); tick();
    checks++; if ({red, green, blue} !== 12'h000) begin errors++; $display("FAIL comp_blank got %h want 000", {red, green, blue}); end
  endtask

  task automatic test_random_pixels();
    rec_t        q[$];
    rec_t        r, cur;
    logic [11:0] exp_rgb;
    bit          exp_vld;
    int          sx[N], sy[N];
    int          px, py;
    bit          hi;
    for (int k = 0; k < 1500; k++) begin
      hi = ($urandom_range(0, 3) == 0);
      px = hi ? int'($urandom_range(1000, 1023)) : int'($urandom_range(0, 60));
      py = hi ? int'($urandom_range(1000, 1023)) : int'($urandom_range(0, 60));
      for (int i = 0; i < N; i++) begin
        sx[i] = hi ? int'($urandom_range(1000, 1023)) : int'($urandom_range(0, 60));
        sy[i] = hi ? int'($urandom_range(1000, 1023)) : int'($urandom_range(0, 60));
        snake_x[10*i +: 10] = 10'(sx[i]);
        snake_y[10*i +: 10] = 10'(sy[i]);
        sprite_rgb[12*i +: 12] = ($urandom_range(0, 2) == 0) ? KEY : 12'($urandom);
      end
      DrawX = 10'(px); DrawY = 10'(py);
      blank = ($urandom_range(0, 7) != 0);
      bgd_rgb = 12'($urandom);
      #1;
      cur.b = blank;
      for (int i = 0; i < N; i++) begin
        cur.h[i] = m_hit(px, py, sx[i], sy[i]);
        if (cur.h[i]) begin
          checks++;
          if (sprite_addr[AW*i +: AW] !== AW'(m_addr(px, py, sx[i], sy[i]))) begin
            errors++;
            $display("FAIL rnd_addr%0d px=%0d py=%0d got %0d want %0d", i, px, py, sprite_addr[AW*i +: AW], m_addr(px, py, sx[i], sy[i]));
          end
        end
      end
      exp_vld = 1'b0; exp_rgb = '0;
      if (q.size() == L) begin
        r = q.pop_front();
        exp_vld = 1'b1;
        exp_rgb = m_pix(r.b, r.h, sprite_rgb, bgd_rgb);
      end
      q.push_back(cur);
      tick();
      if (exp_vld) begin
        checks++;
        if ({red, green, blue} !== exp_rgb) begin
          errors++;
          $display("FAIL rnd_rgb cycle %0d got %h want %h", k, {red, green, blue}, exp_rgb);
        end
      end
    end
  endtask

  task automatic test_direction();
    logic [1:0] pend[N], comm[N];
    logic [1:0] rq;
    bit         lg, fs;
    blank = 1'b0; dir_valid = '0; frame_start = 1'b0;
    do_reset();
    dir_valid = 2'b01; dir_req = {2'b11, 2'b01};
    tick();
    dir_valid = '0; frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    checks++; if (sprite_dir[1:0] !== 2'b11) begin errors++; $display("FAIL dir_reversal got %b want 11", sprite_dir[1:0]); end
    dir_valid = 2'b01; dir_req = {2'b11, 2'b00};
    tick();
    dir_valid = '0;
    checks++; if (sprite_dir[1:0] !== 2'b11) begin errors++; $display("FAIL dir_midframe got %b want 11", sprite_dir[1:0]); end
    tick(); tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    checks++; if (sprite_dir[1:0] !== 2'b00) begin errors++; $display("FAIL dir_commit got %b want 00", sprite_dir[1:0]); end
    dir_valid = 2'b10; dir_req = {2'b00, 2'b00}; frame_start = 1'b1;
    tick();
    dir_valid = '0; frame_start = 1'b0;
    checks++; if (sprite_dir[3:2] !== 2'b00) begin errors++; $display("FAIL dir_same_cycle got %b want 00", sprite_dir[3:2]); end
    dir_valid = 2'b01; dir_req = {2'b00, 2'b10};
    tick();
    dir_valid = '0; frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    checks++; if (sprite_dir[1:0] !== 2'b00) begin errors++; $display("FAIL dir_rev_down got %b want 00", sprite_dir[1:0]); end

    do_reset();
    for (int i = 0; i < N; i++) begin pend[i] = RD; comm[i] = RD; end
    for (int k = 0; k < 400; k++) begin
      dir_valid = N'($urandom);
      dir_req = (2*N)'($urandom);
      fs = ($urandom_range(0, 5) == 0);
      frame_start = fs;
      for (int i = 0; i < N; i++) begin
        rq = dir_req[2*i +: 2];
        lg = dir_valid[i] && !(rq[1] != comm[i][1] && rq[0] == comm[i][0]);
        if (fs) begin
          if (lg) begin pend[i] = rq; comm[i] = rq; end
          else comm[i] = pend[i];
        end else if (lg) begin
          pend[i] = rq;
        end
      end
      tick();
      checks++;
      if (sprite_dir !== {comm[1], comm[0]}) begin
        errors++;
        $display("FAIL rnd_dir cycle %0d got %b want %b", k, sprite_dir, {comm[1], comm[0]});
      end
    end
    dir_valid = '0; frame_start = 1'b0;
  endtask

  task automatic test_collision();
    logic [N-1:0] exp_m;
    exp_m = CE ? {N{1'b1}} : '0;
    do_reset();
    snake_x = {10'd300, 10'd300}; snake_y = {10'd300, 10'd300};
    DrawX = 10'd300; DrawY = 10'd300; sprite_rgb = {12'h0A0, 12'h123}; bgd_rgb = 12'h000;
    blank = 1'b0; frame_start = 1'b1;
    tick();
    frame_start = 1'b0; blank = 1'b1;
    tick();
    blank = 1'b0;
    tick(); tick();
    checks++; if (collision !== 1'b0) begin errors++; $display("FAIL coll_early got %b want 0", collision); end
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    checks++; if (collision !== CE || collision_mask !== exp_m) begin errors++; $display("FAIL coll_frameN got %b/%b want %b/%b", collision, collision_mask, CE, exp_m); end
    tick(); tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    checks++; if (collision !== 1'b0 || collision_mask !== '0) begin errors++; $display("FAIL coll_clean got %b/%b want 0/00", collision, collision_mask); end
    blank = 1'b1;
    tick();
    blank = 1'b0; frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    checks++; if (collision !== 1'b0) begin errors++; $display("FAIL coll_fs_edge_old got %b want 0", collision); end
    tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    checks++; if (collision !== CE || collision_mask !== exp_m) begin errors++; $display("FAIL coll_fs_edge_new got %b/%b want %b/%b", collision, collision_mask, CE, exp_m); end
  endtask

  task automatic test_reset_midframe();
    snake_x = {10'd800, 10'd400}; snake_y = {10'd100, 10'd300};
    DrawX = 10'd400; DrawY = 10'd300; blank = 1'b1;
    sprite_rgb = {12'h0A0, 12'h5A3}; bgd_rgb = 12'h111;
    dir_valid = 2'b01; dir_req = {2'b11, 2'b00}; frame_start = 1'b1;
    tick();
    dir_valid = '0; frame_start = 1'b0;
    tick(); tick();
    checks++; if ({red, green, blue} !== 12'h5A3 || sprite_dir[1:0] !== 2'b00) begin errors++; $display("FAIL pre_reset got %h/%b want 5a3/00", {red, green, blue}, sprite_dir[1:0]); end
    Reset = 1'b1;
    tick();
    checks++; if ({red, green, blue} !== 12'h000) begin errors++; $display("FAIL midreset_rgb got %h want 000", {red, green, blue}); end
    checks++; if (sprite_dir !== {RD, RD}) begin errors++; $display("FAIL midreset_dir got %b want %b", sprite_dir, {RD, RD}); end
    checks++; if (collision !== 1'b0 || collision_mask !== '0) begin errors++; $display("FAIL midreset_coll got %b/%b want 0/00", collision, collision_mask); end
    Reset = 1'b0;
    for (int j = 1; j <= L; j++) begin
      tick();
      checks++; if ({red, green, blue} !== 12'h000) begin errors++; $display("FAIL post_reset_stale%0d got %h want 000", j, {red, green, blue}); end
    end
    tick();
    checks++; if ({red, green, blue} !== 12'h5A3) begin errors++; $display("FAIL post_reset_first got %h want 5a3", {red, green, blue}); end
  endtask

  initial begin
    test_reset();
    test_addr();
    test_composite();
    test_random_pixels();
    test_direction();
    test_collision();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
